vx_commit_packet_merger: RTL and testbench



---
 rtl/vx_commit_packet_merger_pkg.sv | 37 +++
 rtl/vx_lane_scatter.sv | 36 +++
 rtl/vx_commit_packet_merger.sv | 136 +++++++++++++
 tb/tb_vx_commit_packet_merger.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_commit_packet_merger_pkg.sv
// Shared types and helpers for the commit-side packet merger.
//   merge_state_e    : merger FSM states (IDLE / ACCUM / FULL)
//   calc_num_packets : packets per instruction for a given warp/lane split
//   calc_pid_width   : packet-id width, never narrower than 1 bit
//   commit_hdr_t     : commit header {uuid, wid, pc, wb, rd} at the default
//                      machine widths, shared with the dispatch commit interface
package vx_commit_packet_merger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FULL  = 2'd2
  } merge_state_e;

  function automatic int calc_num_packets(input int num_threads, input int num_lanes);
    return num_threads / num_lanes;
  endfunction

  // A single-packet split still carries a 1-bit pid that is always zero.
  function automatic int calc_pid_width(input int num_packets);
    return (num_packets > 1) ? $clog2(num_packets) : 1;
  endfunction

  localparam int HDR_UUID_WIDTH = 1;
  localparam int HDR_NW_WIDTH   = 2;
  localparam int HDR_XLEN       = 32;
  localparam int HDR_NR_BITS    = 5;

  typedef struct packed {
    logic [HDR_UUID_WIDTH-1:0] uuid;
    logic [HDR_NW_WIDTH-1:0]   wid;
    logic [HDR_XLEN-1:0]       pc;
    logic                      wb;
    logic [HDR_NR_BITS-1:0]    rd;
  } commit_hdr_t;

endpackage

// File: rtl/vx_lane_scatter.sv
// Combinational decode that places one NUM_LANES-wide packet at its pid
// offset inside a NUM_THREADS-wide vector.
//   pid        : packet index; slot base = pid * NUM_LANES
//   lane_tmask : packet lane mask
//   lane_data  : packet lane data, lane j at [j*XLEN +: XLEN]
//   wr_en      : per-slot write enable (slot belongs to this pid)
//   wr_tmask   : per-slot mask value to write
//   wr_data    : per-slot data value to write
module vx_lane_scatter
  import vx_commit_packet_merger_pkg::*;
#(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_LANES   = 2,
  parameter  int XLEN        = 32,
  localparam int PID_WIDTH   = calc_pid_width(calc_num_packets(NUM_THREADS, NUM_LANES))
) (
  input  logic [PID_WIDTH-1:0]        pid,
  input  logic [NUM_LANES-1:0]        lane_tmask,
  input  logic [NUM_LANES*XLEN-1:0]   lane_data,
  output logic [NUM_THREADS-1:0]      wr_en,
  output logic [NUM_THREADS-1:0]      wr_tmask,
  output logic [NUM_THREADS*XLEN-1:0] wr_data
);

  // Slot t belongs to packet t/NUM_LANES and takes lane t%NUM_LANES, so
  // each slot only ever muxes from one fixed lane.
  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_slot
    localparam logic [PID_WIDTH-1:0] SLOT_PID = PID_WIDTH'(t / NUM_LANES);
    localparam int                   LANE     = t % NUM_LANES;

    assign wr_en[t]                  = (pid == SLOT_PID);
    assign wr_tmask[t]               = lane_tmask[LANE];
    assign wr_data[t*XLEN +: XLEN]   = lane_data[LANE*XLEN +: XLEN];
  end

endmodule

// File: rtl/vx_commit_packet_merger.sv
// Reassembles the dispatch stage's lane-split packets (pid/sop/eop tagged)
// into one full-width commit transaction.
//   clk, reset          : clock, synchronous active-high reset
//   in_*                : split packet stream (valid/ready), header + lanes
//   out_*               : merged commit stream (valid/ready), header + lanes
//   proto_err           : sticky flag for orphan, restarted or foreign packets
module vx_commit_packet_merger
  import vx_commit_packet_merger_pkg::*;
#(
  parameter  int NUM_THREADS = 4,
  parameter  int NUM_LANES   = 2,
  parameter  int XLEN        = 32,
  parameter  int NW_WIDTH    = 2,
  parameter  int UUID_WIDTH  = 1,
  parameter  int NR_BITS     = 5,
  localparam int PID_WIDTH   = calc_pid_width(calc_num_packets(NUM_THREADS, NUM_LANES))
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_WIDTH-1:0]       in_uuid,
  input  logic [NW_WIDTH-1:0]         in_wid,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [XLEN-1:0]             in_pc,
  input  logic                        in_wb,
  input  logic [NR_BITS-1:0]          in_rd,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_WIDTH-1:0]        in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_WIDTH-1:0]       out_uuid,
  output logic [NW_WIDTH-1:0]         out_wid,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [XLEN-1:0]             out_pc,
  output logic                        out_wb,
  output logic [NR_BITS-1:0]          out_rd,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        proto_err
);

  if (NUM_THREADS % NUM_LANES != 0) begin : g_bad_split
    $error("vx_commit_packet_merger: NUM_THREADS must be a multiple of NUM_LANES");
  end

  merge_state_e state;

  logic [NUM_THREADS-1:0]      wr_en;
  logic [NUM_THREADS-1:0]      wr_tmask;
  logic [NUM_THREADS*XLEN-1:0] wr_data;

  vx_lane_scatter #(
    .NUM_THREADS (NUM_THREADS),
    .NUM_LANES   (NUM_LANES),
    .XLEN        (XLEN)
  ) u_scatter (
    .pid        (in_pid),
    .lane_tmask (in_tmask),
    .lane_data  (in_data),
    .wr_en      (wr_en),
    .wr_tmask   (wr_tmask),
    .wr_data    (wr_data)
  );

  logic in_fire, out_fire, in_accum, hdr_match;
  logic start_pkt, merge_pkt, proto_viol;

  // While FULL an input can only be taken if the held result leaves the
  // same cycle, which makes a sop accepted in FULL a bubble-free hand-off.
  assign in_ready  = (state != ST_FULL) || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign in_accum  = (state == ST_ACCUM);
  assign hdr_match = (in_wid == out_wid) && (in_uuid == out_uuid);

  // A sop always starts a fresh instruction, even on top of an unfinished
  // one; a non-sop only merges into a matching instruction in flight.
  assign start_pkt  = in_fire && in_sop;
  assign merge_pkt  = in_fire && !in_sop && in_accum && hdr_match;
  assign proto_viol = in_fire && (in_sop ? in_accum : !(in_accum && hdr_match));

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      proto_err <= 1'b0;
      out_uuid  <= '0;
      out_wid   <= '0;
      out_pc    <= '0;
      out_wb    <= 1'b0;
      out_rd    <= '0;
      // NOTE: the lane accumulator is reset as well, so slots of packets
      // that were never received read as zero rather than stale lanes.
      out_tmask <= '0;
      out_data  <= '0;
    end else begin
      if (proto_viol) begin
        proto_err <= 1'b1;
      end

      if (start_pkt) begin
        out_uuid <= in_uuid;
        out_wid  <= in_wid;
        out_pc   <= in_pc;
        out_wb   <= in_wb;
        out_rd   <= in_rd;
        // Clear-then-write in one step: slots outside this pid go to zero.
        for (int t = 0; t < NUM_THREADS; t++) begin
          out_tmask[t]               <= wr_en[t] & wr_tmask[t];
          out_data[t*XLEN +: XLEN]   <= wr_en[t] ? wr_data[t*XLEN +: XLEN] : '0;
        end
        state     <= in_eop ? ST_FULL : ST_ACCUM;
        out_valid <= in_eop;
      end else if (merge_pkt) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
          if (wr_en[t]) begin
            out_tmask[t]             <= wr_tmask[t];
            out_data[t*XLEN +: XLEN] <= wr_data[t*XLEN +: XLEN];
          end
        end
        if (in_eop) begin
          state     <= ST_FULL;
          out_valid <= 1'b1;
        end
      end else if (out_fire) begin
        state     <= ST_IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vx_commit_packet_merger.sv
// Directed self-checking bench for vx_commit_packet_merger at the default
// 4-thread / 2-lane split. Lane 0 of every data vector is the low word.
module tb_vx_commit_packet_merger;

  localparam int NT = 4;
  localparam int NL = 2;
  localparam int XL = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [0:0]       in_uuid = '0;
  logic [1:0]       in_wid = '0;
  logic [NL-1:0]    in_tmask = '0;
  logic [XL-1:0]    in_pc = '0;
  logic             in_wb = 1'b0;
  logic [4:0]       in_rd = '0;
  logic [NL*XL-1:0] in_data = '0;
  logic [0:0]       in_pid = '0;
  logic             in_sop = 1'b0;
  logic             in_eop = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [0:0]       out_uuid;
  logic [1:0]       out_wid;
  logic [NT-1:0]    out_tmask;
  logic [XL-1:0]    out_pc;
  logic             out_wb;
  logic [4:0]       out_rd;
  logic [NT*XL-1:0] out_data;
  logic             proto_err;

  int errors = 0;
  int checks = 0;

  vx_commit_packet_merger dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_uuid   (in_uuid),
    .in_wid    (in_wid),
    .in_tmask  (in_tmask),
    .in_pc     (in_pc),
    .in_wb     (in_wb),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .in_pid    (in_pid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uuid  (out_uuid),
    .out_wid   (out_wid),
    .out_tmask (out_tmask),
    .out_pc    (out_pc),
    .out_wb    (out_wb),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  localparam logic [XL-1:0] A = 32'hA0A0_0001, B = 32'hB0B0_0002;
  localparam logic [XL-1:0] C = 32'hC0C0_0003, D = 32'hD0D0_0004;
  localparam logic [XL-1:0] E = 32'hE0E0_0005, X = 32'hDEAD_0000;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic set_pkt(input logic [0:0] pid, input logic sop, input logic eop,
                         input logic [1:0] tmask, input logic [NL*XL-1:0] data,
                         input logic [1:0] wid, input logic [0:0] uuid);
    in_pid = pid; in_sop = sop; in_eop = eop; in_tmask = tmask;
    in_data = data; in_wid = wid; in_uuid = uuid; in_valid = 1'b1;
  endtask

  task automatic drive_pkt(input logic [0:0] pid, input logic sop, input logic eop,
                           input logic [1:0] tmask, input logic [NL*XL-1:0] data,
                           input logic [1:0] wid, input logic [0:0] uuid);
    set_pkt(pid, sop, eop, tmask, data, wid, uuid);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %0b want 0", proto_err); end
    checks++; if (out_tmask !== 4'b0000) begin errors++; $display("FAIL reset_tmask: got %b want 0000", out_tmask); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_two_packet();
    out_ready = 1'b1;
    in_pc = 32'h0000_1000; in_wb = 1'b1; in_rd = 5'd7;
    drive_pkt(1'b0, 1'b1, 1'b0, 2'b11, {B, A}, 2'd1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_pkt_early_valid: got %0b want 0", out_valid); end
    in_pc = 32'h0000_2222; in_wb = 1'b0; in_rd = 5'd30;  // non-sop header must be ignored
    drive_pkt(1'b1, 1'b0, 1'b1, 2'b11, {D, C}, 2'd1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL two_pkt_valid: got %0b want 1", out_valid); end
    checks++; if (out_tmask !== 4'b1111) begin errors++; $display("FAIL two_pkt_tmask: got %b want 1111", out_tmask); end
    checks++; if (out_data !== {D, C, B, A}) begin errors++; $display("FAIL two_pkt_data: got %h want %h", out_data, {D, C, B, A}); end
    checks++; if ({out_uuid, out_wid, out_pc, out_wb, out_rd} !== {1'b1, 2'd1, 32'h0000_1000, 1'b1, 5'd7})
      begin errors++; $display("FAIL two_pkt_header: got %0h/%0h/%h/%0b/%0d want 1/1/00001000/1/7", out_uuid, out_wid, out_pc, out_wb, out_rd); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL two_pkt_drain: got %0b want 0", out_valid); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL two_pkt_proto_err: got %0b want 0", proto_err); end
  endtask

  // Leaves the DUT FULL with out_ready low for test_back_to_back.
  task automatic test_single_packet();
    out_ready = 1'b0;
    drive_pkt(1'b1, 1'b1, 1'b1, 2'b10, {E, X}, 2'd2, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    checks++; if (out_tmask !== 4'b1000) begin errors++; $display("FAIL single_tmask: got %b want 1000", out_tmask); end
    checks++; if (out_data !== {E, X, 32'h0, 32'h0}) begin errors++; $display("FAIL single_data: got %h want %h", out_data, {E, X, 32'h0, 32'h0}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %0b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_tmask !== 4'b1000 || out_data !== {E, X, 32'h0, 32'h0} || out_wid !== 2'd2)
        begin errors++; $display("FAIL hold_stable[%0d]: got v=%0b m=%b w=%0d d=%h", i, out_valid, out_tmask, out_wid, out_data); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    set_pkt(1'b0, 1'b1, 1'b0, 2'b01, {X, C}, 2'd3, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_accum: got %0b want 0", out_valid); end
    drive_pkt(1'b1, 1'b0, 1'b1, 2'b10, {D, X}, 2'd3, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_wid !== 2'd3) begin errors++; $display("FAIL b2b_valid: got v=%0b w=%0d want v=1 w=3", out_valid, out_wid); end
    checks++; if (out_tmask !== 4'b1001) begin errors++; $display("FAIL b2b_tmask: got %b want 1001", out_tmask); end
    checks++; if (out_data !== {D, X, X, C}) begin errors++; $display("FAIL b2b_data: got %h want %h", out_data, {D, X, X, C}); end
    @(posedge clk); #1;
  endtask

  task automatic test_orphan();
    do_reset();
    drive_pkt(1'b1, 1'b0, 1'b1, 2'b11, {D, C}, 2'd0, 1'b0);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL orphan_proto_err: got %0b want 1", proto_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL orphan_valid: got %0b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || proto_err !== 1'b1) begin errors++; $display("FAIL orphan_after: got v=%0b e=%0b want v=0 e=1", out_valid, proto_err); end
  endtask

  task automatic test_sop_restart();
    do_reset();
    drive_pkt(1'b0, 1'b1, 1'b0, 2'b11, {B, A}, 2'd1, 1'b0);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL restart_first: got %0b want 0", proto_err); end
    drive_pkt(1'b1, 1'b1, 1'b0, 2'b11, {D, C}, 2'd2, 1'b0);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL restart_proto_err: got %0b want 1", proto_err); end
    drive_pkt(1'b0, 1'b0, 1'b1, 2'b01, {X, E}, 2'd2, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_wid !== 2'd2) begin errors++; $display("FAIL restart_valid: got v=%0b w=%0d want v=1 w=2", out_valid, out_wid); end
    checks++; if (out_tmask !== 4'b1101) begin errors++; $display("FAIL restart_tmask: got %b want 1101", out_tmask); end
    checks++; if (out_data !== {D, C, X, E}) begin errors++; $display("FAIL restart_data: got %h want %h", out_data, {D, C, X, E}); end
    @(posedge clk); #1;
  endtask

  task automatic test_hdr_mismatch();
    do_reset();
    drive_pkt(1'b0, 1'b1, 1'b0, 2'b11, {B, A}, 2'd1, 1'b0);
    drive_pkt(1'b1, 1'b0, 1'b1, 2'b11, {X, X}, 2'd1, 1'b1);   // uuid differs
    checks++; if (proto_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL uuid_mismatch: got e=%0b v=%0b want e=1 v=0", proto_err, out_valid); end
    drive_pkt(1'b1, 1'b0, 1'b1, 2'b11, {X, X}, 2'd3, 1'b0);   // wid differs
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wid_mismatch: got v=%0b want 0", out_valid); end
    drive_pkt(1'b0, 1'b0, 1'b0, 2'b10, {E, X}, 2'd1, 1'b0);   // duplicate pid0 overwrites
    drive_pkt(1'b1, 1'b0, 1'b1, 2'b01, {D, C}, 2'd1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_tmask !== 4'b0110) begin errors++; $display("FAIL mismatch_merge: got v=%0b m=%b want v=1 m=0110", out_valid, out_tmask); end
    checks++; if (out_data !== {D, C, E, X}) begin errors++; $display("FAIL mismatch_data: got %h want %h", out_data, {D, C, E, X}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_pkt(1'b0, 1'b1, 1'b0, 2'b11, {B, A}, 2'd1, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL midrst_state: got v=%0b e=%0b want 0/0", out_valid, proto_err); end
    drive_pkt(1'b1, 1'b0, 1'b1, 2'b11, {D, C}, 2'd1, 1'b0);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL midrst_proto_err: got %0b want 1", proto_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_after: got %0b want 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_two_packet();
    test_single_packet();
    test_back_to_back();
    test_orphan();
    test_sop_restart();
    test_hdr_mismatch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
